// File: rtl/sensor_debounce.sv
// Debounce front end for the 3-bit water-level sensor: 2-flop synchroniser, stability counter, change strobes.
// Define SENSOR_DEBOUNCE_GLITCH_CNT_EN to add the saturating rejected-candidate counter on glitch_cnt.
module sensor_debounce #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sensor_raw,
    output logic       p,
    output logic       q,
    output logic       r,
    output logic [2:0] sensor,
    output logic       change,
    output logic       level_up
`ifdef SENSOR_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || GLITCH_W < 1) begin : g_bad_params
        $error("sensor_debounce: STABLE_CYCLES must be 2..255 and GLITCH_W >= 1");
    end

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] s1_q, s2_q;
    logic [2:0] sensor_q, sensor_d;
    logic [2:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic       change_q, change_d;
    logic       level_up_q, level_up_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            state_q    <= ST_STABLE;
            sensor_q   <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            change_q   <= 1'b0;
            level_up_q <= 1'b0;
        end else begin
            s1_q       <= sensor_raw;
            s2_q       <= s1_q;
            state_q    <= state_d;
            sensor_q   <= sensor_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            change_q   <= change_d;
            level_up_q <= level_up_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        sensor_d   = sensor_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        change_d   = 1'b0;
        level_up_d = 1'b0;

        case (state_q)
            ST_STABLE: begin
                if (s2_q != sensor_q) begin
                    cand_d  = s2_q;
                    cnt_d   = 8'd1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (s2_q == cand_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == STABLE_LIMIT) begin
                        sensor_d   = cand_q;
                        change_d   = 1'b1;
                        level_up_d = (cand_q > sensor_q);
                        state_d    = ST_STABLE;
                    end
                end else if (s2_q == sensor_q) begin
                    state_d = ST_STABLE;
                end else begin
                    cand_d = s2_q;
                    cnt_d  = 8'd1;
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

`ifdef SENSOR_DEBOUNCE_GLITCH_CNT_EN
    // Abort and restart are exactly the CHECK cycles where the sample departs from the candidate.
    logic                glitch_evt;
    logic [GLITCH_W-1:0] glitch_q;

    assign glitch_evt = (state_q == ST_CHECK) && (s2_q != cand_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else if (glitch_evt && (glitch_q != '1)) begin
            glitch_q <= glitch_q + GLITCH_W'(1);
        end
    end

    assign glitch_cnt = glitch_q;
`endif

    assign sensor    = sensor_q;
    assign {p, q, r} = sensor_q;
    assign change    = change_q;
    assign level_up  = level_up_q;

endmodule
